// File: rtl/cache_data_mem.sv
// Byte-addressed cache data array: word read/write port plus multi-beat block refill port.
// Define CACHE_MEM_BYTE_WRITE_EN to make word writes honour byte_en.
module cache_data_mem #(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BLOCK_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic                    rd,
    input  logic                    wr,
    input  logic                    load_block,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [DATA_WIDTH-1:0]   Data_in,
    input  logic                    beat_valid,
    input  logic [DATA_WIDTH-1:0]   beat_data,
    output logic [DATA_WIDTH-1:0]   Data_out,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    finish_writing_block
);

    localparam int unsigned WB     = DATA_WIDTH / 8;
    localparam int unsigned BEATS  = BLOCK_BYTES / WB;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WB_LOG = $clog2(WB);
    localparam int unsigned IDX_W  = ADDR_WIDTH - WB_LOG;
    localparam int unsigned NWORDS = 2 ** IDX_W;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = ~ADDR_WIDTH'(WB - 1);
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ~ADDR_WIDTH'(BLOCK_BYTES - 1);
    localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BEATS - 1);

    typedef enum logic {StIdle, StFill} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      beat_cnt_q;
    logic [ADDR_WIDTH-1:0] block_addr_q;

    logic                  cmd_ok;
    logic                  do_rd;
    logic                  do_wr;
    logic                  do_load;
    logic                  do_beat;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [IDX_W-1:0]      word_idx;
    logic [IDX_W-1:0]      beat_idx;
    logic [WB-1:0]         wr_be;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_bits;

    always_comb begin
        // More than one command in a cycle is dropped as a whole.
        cmd_ok    = !(rd && wr) && !(rd && load_block) && !(wr && load_block);
        do_rd     = (state_q == StIdle) && cmd_ok && rd;
        do_wr     = (state_q == StIdle) && cmd_ok && wr;
        do_load   = (state_q == StIdle) && cmd_ok && load_block;
        do_beat   = (state_q == StFill) && beat_valid;
        last_beat = do_beat && (beat_cnt_q == LAST_BEAT);
        word_addr = Address & WORD_MASK;
        beat_addr = block_addr_q | (ADDR_WIDTH'(beat_cnt_q) << WB_LOG);
        word_idx  = word_addr[ADDR_WIDTH-1:WB_LOG];
        beat_idx  = beat_addr[ADDR_WIDTH-1:WB_LOG];
    end

`ifdef CACHE_MEM_BYTE_WRITE_EN
    assign wr_be       = byte_en;
    assign unused_bits = ^{word_addr & ~WORD_MASK, beat_addr & ~WORD_MASK};
`else
    assign wr_be       = '1;
    assign unused_bits = ^{word_addr & ~WORD_MASK, beat_addr & ~WORD_MASK, byte_en};
`endif

    // Lane k holds the byte at word offset k. Word port is big-endian, beat port little-endian.
    for (genvar k = 0; k < WB; k++) begin : g_lane
        logic [7:0] lane [NWORDS];
        logic       lane_wr;

        assign lane_wr = do_wr && wr_be[WB-1-k];

        always_ff @(posedge clk) begin
            if (lane_wr) begin
                lane[word_idx] <= Data_in[8*(WB-1-k) +: 8];
            end else if (do_beat) begin
                lane[beat_idx] <= beat_data[8*k +: 8];
            end
        end

        assign rd_word[8*(WB-1-k) +: 8] = lane[word_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q              <= StIdle;
            beat_cnt_q           <= '0;
            block_addr_q         <= '0;
            Data_out             <= '0;
            rd_valid             <= 1'b0;
            busy                 <= 1'b0;
            finish_writing_block <= 1'b0;
        end else begin
            rd_valid             <= do_rd;
            finish_writing_block <= last_beat;
            if (do_rd) begin
                Data_out <= rd_word;
            end
            unique case (state_q)
                StIdle: begin
                    if (do_load) begin
                        state_q      <= StFill;
                        busy         <= 1'b1;
                        beat_cnt_q   <= '0;
                        block_addr_q <= Address & BLOCK_MASK;
                    end
                end
                StFill: begin
                    if (do_beat) begin
                        if (last_beat) begin
                            state_q    <= StIdle;
                            busy       <= 1'b0;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_data_mem.md
# cache_data_mem

Parametrised byte-addressed data array for the RISC-V integrated cache.
- Serves single-word reads with 1-cycle registered latency.
- Serves single-word writes, with optional byte enables.
- Fills a whole block in multiple beats from the memory side, with a busy/finish handshake.
- Sits between the cache controller (word port) and the refill path from main memory (beat port). Tag/valid storage lives outside this block.

## Interface

Parameters:
- ADDR_WIDTH, 9: byte-address width; array holds 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 32: word width and refill beat width; multiple of 8.
- BLOCK_BYTES, 16: block size in bytes; power of two, multiple of DATA_WIDTH/8.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- Address, input, ADDR_WIDTH: byte address for rd, wr and load_block.
- rd, input, 1: word read request.
- wr, input, 1: word write request.
- load_block, input, 1: start a block fill.
- byte_en, input, DATA_WIDTH/8: write byte enables; bit i covers Data_in[8i+7:8i].
- Data_in, input, DATA_WIDTH: write data.
- beat_valid, input, 1: refill beat present.
- beat_data, input, DATA_WIDTH: refill beat.
- Data_out, output, DATA_WIDTH: read data, registered.
- rd_valid, output, 1: Data_out updated this cycle.
- busy, output, 1: fill in progress.
- finish_writing_block, output, 1: one-cycle pulse after the last beat is written.

## Operation

Derived values:
- WB = DATA_WIDTH/8.
- BEATS = BLOCK_BYTES/WB.
- Word address = Address with low log2(WB) bits cleared.
- Block address = Address with low log2(BLOCK_BYTES) bits cleared.

Commands and state:
- rd, wr and load_block are one-hot. Any cycle with more than one asserted is ignored entirely, with no state change.
- States: IDLE and FILL.
- IDLE -> FILL on load_block. Latch the block address and clear the beat counter.
- FILL -> IDLE when the beat with counter == BEATS-1 is accepted.

Read:
- In IDLE, rd at edge N loads Data_out with the word at the word address and drives rd_valid=1 during cycle N+1.
- Byte order is big-endian: mem[wa] lands in Data_out[DATA_WIDTH-1:DATA_WIDTH-8], mem[wa+WB-1] in [7:0].
- Data_out holds its value when there is no read; it never goes to Z.

Write:
- In IDLE, wr writes Data_in to the word address with the same big-endian mapping, only the enabled bytes.

Fill:
- In FILL, each beat_valid cycle writes beat_data at block address + counter*WB, then increments the counter.
- Beat byte order is little-endian: beat_data[7:0] goes to the lowest address.
- beat_valid may have gaps; the counter only advances on accepted beats.
- In FILL, rd, wr and load_block are ignored: no write, rd_valid stays 0.
- beat_valid in IDLE is ignored.
- Array contents are not reset.
- Reset mid-fill returns to IDLE with counter 0 and no finish pulse. Bytes from beats already written stay in the array.

## Timing

Reset values:
- Data_out=0, rd_valid=0, busy=0, finish_writing_block=0, state IDLE, counter 0.

Cycle behaviour:
- Read latency is 1 cycle.
- A write at edge N followed by a read of the same word at edge N+1 returns the new data.
- busy rises the cycle after load_block is sampled.
- If the last beat is sampled at edge M, then in cycle M+1 busy=0 and finish_writing_block=1 for exactly one cycle.
- load_block sampled at edge M+1 is accepted.
- A full fill with back-to-back beats occupies BEATS cycles of busy.
- Address wrap: block addresses are aligned, so no fill crosses the top of the array.

## Configuration

Macro CACHE_MEM_BYTE_WRITE_EN:
- Defined: writes honour byte_en; disabled bytes keep their old value.
- Undefined: byte_en is ignored and every write updates all WB bytes. The port is still present.

## Test plan

- Reset, then rd at 0x000: rd_valid=1 next cycle; Data_out is array content; busy=0 and finish_writing_block=0 throughout reset.
- wr 0xDEADBEEF at 0x013, then rd at 0x010 next cycle: Data_out=0xDEADBEEF; mem[0x010]=0xDE, mem[0x013]=0xEF.
- load_block at 0x025, then beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with one idle gap:
  - Bytes 0x20..0x2F hold 0x00..0x0F.
  - finish_writing_block pulses exactly once, the cycle after beat 4; busy is high from load+1 through the last-beat cycle.
  - A rd at 0x20 next cycle returns 0x00010203.
- During the fill, issue rd and wr 0xFFFFFFFF at 0x20: rd_valid stays 0 and the bytes keep their fill values.
- With CACHE_MEM_BYTE_WRITE_EN: wr 0xAABBCCDD, byte_en=4'b0101 over word 0x11223344 -> read 0x11BB33DD. Without the macro -> read 0xAABBCCDD.
- Assert rst after beat 2 of a fill: busy=0 immediately, no finish pulse, bytes 0x20..0x27 updated; a new load_block is accepted afterwards.
